// File: rtl/fmul_round_pack_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared constants and types for the single-precision multiply output stage.
//   fp_cls_t     : operand/result class codes (normal, zero, inf, NaN)
//   FP_*         : IEEE-754 single-precision field widths and special values
//   FLAG_*       : bit positions inside the 4-bit {nv, of, uf, nx} flag vector
//   fp_s1_t      : contents of the normalise-stage pipeline register
// No ports; imported by the interface, the rounder and the top.
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MAN_W  = 23;
    localparam int FP_BIAS   = 127;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    // Biased exponent value that no longer fits a finite number (255).
    localparam int FP_EXP_MAX = 2 * FP_BIAS + 1;

    // Widths of the raw inputs coming from the multiplier array.
    localparam int FP_EIN_W  = 10;  // pre-normalisation exponent
    localparam int FP_E_W    = 11;  // internal signed exponent
    localparam int FP_PROD_W = 48;  // full mantissa product

    // Flag vector layout: {nv, of, uf, nx}.
    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [1:0] {
        FP_NORM = 2'b00,
        FP_ZERO = 2'b01,
        FP_INF  = 2'b10,
        FP_NAN  = 2'b11
    } fp_cls_t;

    // Normalise-stage register contents.
    typedef struct packed {
        logic                sign;
        fp_cls_t             cls;     // resolved result class
        logic                nv;      // zero x inf
        logic [FP_MAN_W-1:0] frac;
        logic                guard;
        logic                sticky;
        logic [FP_E_W-1:0]   e;       // two's-complement biased exponent
    } fp_s1_t;

endpackage

// File: rtl/fmul_round_pack_if.sv
// -----------------------------------------------------------------------------
// fmul_round_pack_if
// Bundle between the multiplier array, the round/pack stage and the FP
// register-file writeback.
//   in_valid/in_ready   : input handshake
//   in_sign, in_exp,
//   in_prod, in_a_cls,
//   in_b_cls            : raw multiply result and operand classes
//   out_valid/out_ready : output handshake
//   out_data, out_flags : packed IEEE-754 result and {nv, of, uf, nx}
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; the producer holds its payload stable while valid is high
// and ready is low, and ready never depends on the producer's valid.
// Modports: master = upstream/consumer side (bench), slave = this stage.
// -----------------------------------------------------------------------------
interface fmul_round_pack_if;
    import fp_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sign;
    logic [FP_EIN_W-1:0]   in_exp;
    logic [FP_PROD_W-1:0]  in_prod;
    logic [1:0]            in_a_cls;
    logic [1:0]            in_b_cls;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_data;
    logic [3:0]            out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_prod, in_a_cls, in_b_cls, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_prod, in_a_cls, in_b_cls, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );

endinterface

// File: rtl/fmul_round_pack_rounder.sv
// -----------------------------------------------------------------------------
// fp_rounder
// Combinational rounding of a normalised 23-bit fraction.
//   frac_i, guard_i, sticky_i : normalised fraction and the bits below it
//   e_i                       : signed biased exponent before rounding
//   frac_o, e_o               : rounded fraction, exponent after carry-out
//   nx_o                      : inexact (guard | sticky)
// Build option: FMUL_ROUND_RNE_EN defined selects round-to-nearest-even;
// undefined truncates (the fraction is never incremented).
// -----------------------------------------------------------------------------
module fp_rounder
    import fp_pkg::*;
(
    input  logic [FP_MAN_W-1:0] frac_i,
    input  logic                guard_i,
    input  logic                sticky_i,
    input  logic [FP_E_W-1:0]   e_i,
    output logic [FP_MAN_W-1:0] frac_o,
    output logic [FP_E_W-1:0]   e_o,
    output logic                nx_o
);

    logic          inc;
    logic [FP_MAN_W:0] sum;

    always_comb begin
        inc = 1'b0;
`ifdef FMUL_ROUND_RNE_EN
        // Round up above the halfway point, and on an exact tie only when
        // that makes the fraction even.
        inc = guard_i & (sticky_i | frac_i[0]);
`endif
        sum  = {1'b0, frac_i} + {{FP_MAN_W{1'b0}}, inc};
        nx_o = guard_i | sticky_i;

        // Carry out of the fraction: mantissa becomes 1.0 x 2^(e+1).
        if (sum[FP_MAN_W]) begin
            frac_o = '0;
            e_o    = e_i + {{(FP_E_W-1){1'b0}}, 1'b1};
        end else begin
            frac_o = sum[FP_MAN_W-1:0];
            e_o    = e_i;
        end
    end

endmodule

// File: rtl/fmul_round_pack.sv
// -----------------------------------------------------------------------------
// fmul_round_pack
// Output stage of the single-precision multiply path: normalise (stage 1),
// then round, range-check and pack (stage 2). Two-deep valid/ready pipeline,
// latency 2, one result per cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fmul_round_pack_if.slave (input bundle, output result + flags)
// Rounding mode is chosen inside fp_rounder by FMUL_ROUND_RNE_EN.
// Both stages advance together on adv = !out_valid | out_ready.
// -----------------------------------------------------------------------------
module fmul_round_pack
    import fp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    fmul_round_pack_if.slave      bus
);

    logic        adv;

    fp_s1_t      s1_d, s1_q;
    logic        s1_valid_d, s1_valid_q;

    logic        out_valid_d, out_valid_q;
    logic [31:0] out_data_d,  out_data_q;
    logic [3:0]  out_flags_d, out_flags_q;

    // Stage-1 combinational values
    logic        prod_hi;
    fp_cls_t     a_cls, b_cls;
    fp_s1_t      s1_new;

    // Stage-2 combinational values
    logic [FP_MAN_W-1:0] frac_rnd;
    logic [FP_E_W-1:0]   e_rnd;
    logic                nx_rnd;
    logic [31:0]         res_data;
    logic [3:0]          res_flags;

    assign adv          = !out_valid_q | bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = out_flags_q;

    // ---------------- stage 1: normalise and classify ----------------
    always_comb begin
        a_cls   = fp_cls_t'(bus.in_a_cls);
        b_cls   = fp_cls_t'(bus.in_b_cls);
        prod_hi = bus.in_prod[FP_PROD_W-1];

        s1_new.sign = bus.in_sign;
        s1_new.nv   = 1'b0;
        // Product lies in [1,4): bit 47 set means one extra integer bit.
        if (prod_hi) begin
            s1_new.frac   = bus.in_prod[46:24];
            s1_new.guard  = bus.in_prod[23];
            s1_new.sticky = |bus.in_prod[22:0];
        end else begin
            s1_new.frac   = bus.in_prod[45:23];
            s1_new.guard  = bus.in_prod[22];
            s1_new.sticky = |bus.in_prod[21:0];
        end
        s1_new.e = {bus.in_exp[FP_EIN_W-1], bus.in_exp}
                 + {{(FP_E_W-1){1'b0}}, prod_hi};

        // NaN beats inf beats zero; zero x inf is an invalid operation.
        if (a_cls == FP_NAN || b_cls == FP_NAN) begin
            s1_new.cls = FP_NAN;
        end else if ((a_cls == FP_ZERO && b_cls == FP_INF) ||
                     (a_cls == FP_INF  && b_cls == FP_ZERO)) begin
            s1_new.cls = FP_NAN;
            s1_new.nv  = 1'b1;
        end else if (a_cls == FP_INF || b_cls == FP_INF) begin
            s1_new.cls = FP_INF;
        end else if (a_cls == FP_ZERO || b_cls == FP_ZERO) begin
            s1_new.cls = FP_ZERO;
        end else begin
            s1_new.cls = FP_NORM;
        end

        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (adv) begin
            s1_valid_d = bus.in_valid;
            s1_d       = s1_new;
        end
    end

    // ---------------- stage 2: round, range-check, pack ----------------
    fp_rounder u_rounder (
        .frac_i   (s1_q.frac),
        .guard_i  (s1_q.guard),
        .sticky_i (s1_q.sticky),
        .e_i      (s1_q.e),
        .frac_o   (frac_rnd),
        .e_o      (e_rnd),
        .nx_o     (nx_rnd)
    );

    always_comb begin
        res_data  = '0;
        res_flags = '0;
        unique case (s1_q.cls)
            FP_NAN: begin
                res_data           = FP_QNAN;
                res_flags[FLAG_NV] = s1_q.nv;
            end
            FP_INF: begin
                res_data = {s1_q.sign, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};
            end
            FP_ZERO: begin
                res_data = {s1_q.sign, {(FP_EXP_W+FP_MAN_W){1'b0}}};
            end
            default: begin
                if (!e_rnd[FP_E_W-1] && e_rnd >= FP_E_W'(FP_EXP_MAX)) begin
                    res_data           = {s1_q.sign, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};
                    res_flags[FLAG_OF] = 1'b1;
                    res_flags[FLAG_NX] = 1'b1;
                end else if (e_rnd[FP_E_W-1] || e_rnd == '0) begin
                    // Flush to zero: no denormal results.
                    res_data           = {s1_q.sign, {(FP_EXP_W+FP_MAN_W){1'b0}}};
                    res_flags[FLAG_UF] = 1'b1;
                    res_flags[FLAG_NX] = 1'b1;
                end else begin
                    res_data           = {s1_q.sign, e_rnd[FP_EXP_W-1:0], frac_rnd};
                    res_flags[FLAG_NX] = nx_rnd;
                end
            end
        endcase

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        if (adv) begin
            out_valid_d = s1_valid_q;
            // Only real results overwrite the output registers, so the
            // output is quiet while bubbles pass.
            if (s1_valid_q) begin
                out_data_d  = res_data;
                out_flags_d = res_flags;
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

endmodule
